// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory port arbiter.
//   ADDR_W / DATA_W : word address and data widths of the 256x16 memory
//   PORT_CPU / PORT_DBG : bit positions of each requester in req/gnt vectors
//   arb_state_e : arbiter FSM encoding (also exported on OwnerOut)
package dmem_arb_pkg;

    localparam int unsigned ADDR_W   = 8;
    localparam int unsigned DATA_W   = 16;

    localparam int unsigned PORT_CPU = 0;
    localparam int unsigned PORT_DBG = 1;

    typedef enum logic [1:0] {
        ST_ARB    = 2'b00,
        ST_LOCKED = 2'b01,
        ST_DRAIN  = 2'b10
    } arb_state_e;

endpackage

// File: rtl/dmem_port_arbiter_rr_pick2.sv
// Two-way round-robin picker.
//   req  : request vector, bit PORT_CPU / PORT_DBG
//   last : port granted most recently (0 = CPU, 1 = Dbg)
//   gnt  : one-hot-or-zero grant; on contention the port other than last wins
module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = '0;
        if (req[PORT_CPU] && req[PORT_DBG]) begin
            if (last == 1'(PORT_DBG)) begin
                gnt[PORT_CPU] = 1'b1;
            end else begin
                gnt[PORT_DBG] = 1'b1;
            end
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates a CPU port and a debug-loader port onto one single-port
// 256x16 data memory, one command per cycle.
//   Clk, Rst                  : clock, synchronous active-high reset
//   Cpu*                      : CPU request/write/address/data, grant, read return
//   Dbg*                      : debug request/write/lock/address/data, grant, read return
//   MemAddr/MemWData/MemWrite : memory command of the granted port (zero when idle)
//   MemRData                  : registered memory read data (1-cycle latency)
//   OwnerOut                  : current FSM state
module dmem_port_arbiter
    import dmem_arb_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst,
    input  logic              CpuReq,
    input  logic              CpuWr,
    input  logic [ADDR_W-1:0] CpuAddr,
    input  logic [DATA_W-1:0] CpuWData,
    output logic              CpuGnt,
    output logic              CpuRValid,
    output logic [DATA_W-1:0] CpuRData,
    input  logic              DbgReq,
    input  logic              DbgWr,
    input  logic              DbgLock,
    input  logic [ADDR_W-1:0] DbgAddr,
    input  logic [DATA_W-1:0] DbgWData,
    output logic              DbgGnt,
    output logic              DbgRValid,
    output logic [DATA_W-1:0] DbgRData,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    output logic              MemWrite,
    input  logic [DATA_W-1:0] MemRData,
    output logic [1:0]        OwnerOut
);

    arb_state_e        state_q, state_d;
    logic              last_q, last_d;
    logic [1:0]        rd_pend_q, rd_pend_d;
    logic [DATA_W-1:0] cpu_hold_q, dbg_hold_q;
    logic [1:0]        req, rr_gnt, gnt, rvalid;

    assign req[PORT_CPU] = CpuReq;
    assign req[PORT_DBG] = DbgReq;

    rr_pick2 u_rr (
        .req  (req),
        .last (last_q),
        .gnt  (rr_gnt)
    );

    always_comb begin
        gnt     = '0;
        state_d = state_q;
        last_d  = last_q;
        if (!Rst) begin
            case (state_q)
                ST_ARB: begin
                    gnt = rr_gnt;
                    if (gnt[PORT_DBG] && DbgLock) state_d = ST_LOCKED;
                end
                ST_LOCKED: begin
                    gnt[PORT_DBG] = DbgReq;
                    if (!DbgLock) state_d = ST_DRAIN;
                end
                ST_DRAIN: begin
                    // CPU starved while locked, so it gets first pick here.
                    if (CpuReq) gnt[PORT_CPU] = 1'b1;
                    else        gnt[PORT_DBG] = DbgReq;
                    state_d = ST_ARB;
                end
                default: state_d = ST_ARB;
            endcase
            if (gnt[PORT_CPU])      last_d = 1'(PORT_CPU);
            else if (gnt[PORT_DBG]) last_d = 1'(PORT_DBG);
        end
        rd_pend_d[PORT_CPU] = gnt[PORT_CPU] & ~CpuWr;
        rd_pend_d[PORT_DBG] = gnt[PORT_DBG] & ~DbgWr;
    end

    always_comb begin
        MemAddr  = '0;
        MemWData = '0;
        MemWrite = 1'b0;
        if (gnt[PORT_CPU]) begin
            MemAddr  = CpuAddr;
            MemWData = CpuWData;
            MemWrite = CpuWr;
        end else if (gnt[PORT_DBG]) begin
            MemAddr  = DbgAddr;
            MemWData = DbgWData;
            MemWrite = DbgWr;
        end
    end

    // A read granted just before reset must not surface during the reset cycle.
    assign rvalid    = rd_pend_q & {2{~Rst}};
    assign CpuGnt    = gnt[PORT_CPU];
    assign DbgGnt    = gnt[PORT_DBG];
    assign CpuRValid = rvalid[PORT_CPU];
    assign DbgRValid = rvalid[PORT_DBG];
    // Read data passes straight from the memory register when valid,
    // otherwise the last returned word is held.
    assign CpuRData  = rvalid[PORT_CPU] ? MemRData : cpu_hold_q;
    assign DbgRData  = rvalid[PORT_DBG] ? MemRData : dbg_hold_q;
    assign OwnerOut  = state_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= ST_ARB;
            last_q     <= 1'(PORT_DBG);
            rd_pend_q  <= '0;
            cpu_hold_q <= '0;
            dbg_hold_q <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            rd_pend_q <= rd_pend_d;
            if (rvalid[PORT_CPU]) cpu_hold_q <= MemRData;
            if (rvalid[PORT_DBG]) dbg_hold_q <= MemRData;
        end
    end

endmodule
